// File: rtl/simd_shift_seq.sv
// Multi-cycle SIMD shift sequencer: accepts a command, applies one single-bit
// per-lane shift per clock up to the clipped amount, then holds the result.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no command held, ready to accept
// SHIFT | shifting acc one bit per lane per clock, cnt steps remaining
// DONE  | result registered on out_data/out_valid, waiting for out_ready
module simd_shift_seq #(
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic [1:0]       in_mode,
   input  logic             in_left,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             busy
);

   localparam int CNT_W = (AMT_W > 4) ? AMT_W : 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [7:0]       acc, acc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       mode_q, mode_nxt;
   logic             left_q, left_nxt;
   logic             out_valid_nxt;
   logic [7:0]       out_data_nxt;
   logic [7:0]       acc_shift;
   logic [CNT_W-1:0] amt_ext;
   logic [CNT_W-1:0] in_lane_w;
   logic [CNT_W-1:0] in_cnt;
   logic             load;

   function automatic logic [CNT_W-1:0] lane_width(input logic [1:0] mode);
      case (mode)
         2'b01:   lane_width = CNT_W'(4);
         2'b10:   lane_width = CNT_W'(2);
         default: lane_width = CNT_W'(8);
      endcase
   endfunction

   // Bits that would cross into a neighbouring lane are masked off: the lane
   // LSBs after a left shift, the lane MSBs after a right shift.
   function automatic logic [7:0] shift_one(input logic [7:0] a,
                                            input logic [1:0] mode,
                                            input logic       left);
      logic [7:0] lsb_mask;
      logic [7:0] msb_mask;
      case (mode)
         2'b01: begin
            lsb_mask = 8'h11;
            msb_mask = 8'h88;
         end
         2'b10: begin
            lsb_mask = 8'h55;
            msb_mask = 8'hAA;
         end
         default: begin
            lsb_mask = 8'h01;
            msb_mask = 8'h80;
         end
      endcase
      if (left) shift_one = {a[6:0], 1'b0} & ~lsb_mask;
      else      shift_one = {1'b0, a[7:1]} & ~msb_mask;
   endfunction

   assign amt_ext   = CNT_W'(in_amt);
   assign in_lane_w = lane_width(in_mode);
   assign in_cnt    = (amt_ext >= in_lane_w) ? in_lane_w : amt_ext;
   assign acc_shift = shift_one(acc, mode_q, left_q);

   // A zero-count command sits in DONE for one clock with out_valid low before
   // the result is registered; in_ready stays low until that result retires.
   assign in_ready = (state == S_IDLE) ||
                     ((state == S_DONE) && out_valid && out_ready);
   assign busy     = (state != S_IDLE);

   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc;
      cnt_nxt       = cnt;
      mode_nxt      = mode_q;
      left_nxt      = left_q;
      out_valid_nxt = out_valid;
      out_data_nxt  = out_data;
      load          = 1'b0;

      case (state)
         S_IDLE: begin
            if (in_valid) load = 1'b1;
         end
         S_SHIFT: begin
            acc_nxt = acc_shift;
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) begin
               state_nxt     = S_DONE;
               out_valid_nxt = 1'b1;
               out_data_nxt  = acc_shift;
            end
         end
         S_DONE: begin
            if (!out_valid) begin
               out_valid_nxt = 1'b1;
               out_data_nxt  = acc;
            end else if (out_ready) begin
               out_valid_nxt = 1'b0;
               if (in_valid) load = 1'b1;
               else          state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt     = S_IDLE;
            out_valid_nxt = 1'b0;
         end
      endcase

      if (load) begin
         acc_nxt       = in_data;
         cnt_nxt       = in_cnt;
         mode_nxt      = in_mode;
         left_nxt      = in_left;
         out_valid_nxt = 1'b0;
         state_nxt     = (in_cnt == '0) ? S_DONE : S_SHIFT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         acc       <= '0;
         cnt       <= '0;
         mode_q    <= '0;
         left_q    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         cnt       <= cnt_nxt;
         mode_q    <= mode_nxt;
         left_q    <= left_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
      end
   end

endmodule

// File: tb/tb_simd_shift_seq.sv
// Bench for simd_shift_seq: lane-arithmetic reference model with a per-cycle
// compare process, plus directed cases with hand-computed results.
module tb_simd_shift_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_mode;
   logic       in_left;
   logic [2:0] in_amt;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;

   int total = 0;
   int bad   = 0;

   simd_shift_seq #(.AMT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_left   (in_left),
      .in_amt    (in_amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Each lane is an independent w-bit number shifted by n, where n is the
   // requested amount clipped to the lane width.
   function automatic int lane_w_of(input int mode);
      if (mode == 1) return 4;
      if (mode == 2) return 2;
      return 8;
   endfunction

   function automatic int model_result(input int d, input int mode, input int left, input int amt);
      int w, n, mask, res, v;
      w    = lane_w_of(mode);
      n    = (amt > w) ? w : amt;
      mask = (1 << w) - 1;
      res  = 0;
      for (int l = 0; l < 8 / w; l++) begin
         v = (d >> (l * w)) & mask;
         v = left ? ((v << n) & mask) : (v >> n);
         res = res | (v << (l * w));
      end
      return res;
   endfunction

   function automatic int model_latency(input int mode, input int amt);
      int w, n;
      w = lane_w_of(mode);
      n = (amt > w) ? w : amt;
      return (n < 1) ? 1 : n;
   endfunction

   // Reference model: busy flag, countdown to result, held result.
   bit m_busy, m_valid;
   int m_count, m_result, m_data;
   bit m_in_ready;
   bit run_cmp = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  = 0;
         m_valid = 0;
         m_count = 0;
         m_data  = 0;
      end else begin
         bit acc_ok, hs;
         acc_ok = in_valid && (!m_busy || (m_valid && out_ready));
         hs     = m_valid && out_ready;
         if (hs) begin
            m_valid = 0;
            m_busy  = 0;
         end else if (m_busy && !m_valid) begin
            m_count--;
            if (m_count == 0) begin
               m_valid = 1;
               m_data  = m_result;
            end
         end
         if (acc_ok) begin
            m_busy   = 1;
            m_valid  = 0;
            m_result = model_result(in_data, in_mode, in_left, in_amt);
            m_count  = model_latency(in_mode, in_amt);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && run_cmp) begin
         m_in_ready = !m_busy || (m_valid && out_ready);
         chk("cmp_out_valid", out_valid, m_valid);
         chk("cmp_busy", busy, m_busy);
         chk("cmp_in_ready", in_ready, m_in_ready);
         if (m_valid) chk("cmp_out_data", out_data, m_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         step();
         n++;
      end
      chk("wait_idle_timeout", busy, 1'b0);
   endtask

   task automatic directed(input logic [7:0] d, input logic [1:0] m, input logic l,
                           input logic [2:0] a, input logic [7:0] exp, input int exp_lat);
      int lat;
      chk("model_pin", model_result(d, m, l, a), exp);
      wait_idle();
      in_valid  = 1'b1;
      in_data   = d;
      in_mode   = m;
      in_left   = l;
      in_amt    = a;
      out_ready = 1'b1;
      chk("dir_in_ready_idle", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_amt   = 3'($urandom);
      chk("dir_in_ready_after_accept", in_ready, 1'b0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk("dir_latency", lat, exp_lat);
      chk("dir_out_data", out_data, exp);
      step();
   endtask

   initial begin
      int n;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = '0;
      in_left   = 1'b0;
      in_amt    = '0;
      out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      step();
      step();
      rst_n = 1'b1;
      run_cmp = 1;

      directed(8'hB3, 2'b00, 1'b1, 3'd3, 8'h98, 3);
      directed(8'hB3, 2'b00, 1'b0, 3'd3, 8'h16, 3);
      directed(8'hB3, 2'b01, 1'b0, 3'd1, 8'h51, 1);
      directed(8'hB3, 2'b01, 1'b1, 3'd2, 8'hCC, 2);
      directed(8'hB3, 2'b10, 1'b1, 3'd1, 8'h22, 1);
      directed(8'hB3, 2'b10, 1'b0, 3'd1, 8'h51, 1);
      directed(8'hB3, 2'b10, 1'b1, 3'd7, 8'h00, 2);
      directed(8'h5A, 2'b00, 1'b1, 3'd0, 8'h5A, 1);
      directed(8'h5A, 2'b10, 1'b0, 3'd0, 8'h5A, 1);
      directed(8'hB3, 2'b11, 1'b1, 3'd3, 8'h98, 3);
      directed(8'hFF, 2'b01, 1'b0, 3'd7, 8'h00, 4);

      // Backpressure in DONE, then retire and accept on the same edge.
      wait_idle();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h0F;
      in_mode   = 2'b00;
      in_left   = 1'b1;
      in_amt    = 3'd2;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      chk("bp_first_data", out_data, 8'h3C);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_amt   = 3'($urandom);
         step();
         chk("bp_hold_valid", out_valid, 1'b1);
         chk("bp_hold_data", out_data, 8'h3C);
         chk("bp_hold_in_ready", in_ready, 1'b0);
      end
      in_data   = 8'h81;
      in_mode   = 2'b10;
      in_left   = 1'b0;
      in_amt    = 3'd1;
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      chk("bp_b2b_busy", busy, 1'b1);
      chk("bp_b2b_valid_dropped", out_valid, 1'b0);
      step();
      chk("bp_b2b_valid", out_valid, 1'b1);
      chk("bp_b2b_data", out_data, 8'h40);
      step();

      // Asynchronous reset between edges in the middle of a long shift.
      wait_idle();
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_mode  = 2'b00;
      in_left  = 1'b1;
      in_amt   = 3'd7;
      step();
      in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_out_data", out_data, 8'h00);
      chk("arst_busy", busy, 1'b0);
      chk("arst_in_ready", in_ready, 1'b1);
      step();
      rst_n = 1'b1;
      directed(8'hB3, 2'b00, 1'b0, 3'd3, 8'h16, 3);

      // Randomized traffic, checked every cycle by the compare process.
      for (int i = 0; i < 600; i++) begin
         in_valid  = 1'($urandom);
         in_data   = 8'($urandom);
         in_mode   = 2'($urandom);
         in_left   = 1'($urandom);
         in_amt    = 3'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
